// File: rtl/dualmem_pkg.sv
// Shared types and constants for the dual-port byte-enabled memory.
package dualmem_pkg;

    typedef enum logic [1:0] {
        StReset,
        StClear,
        StReady
    } state_e;

    localparam int unsigned RD_LAT_ONE = 1;
    localparam int unsigned RD_LAT_TWO = 2;

endpackage

// File: rtl/dualmem_rdpipe.sv
// Read-return pipeline: aligns valid/data to the configured latency and holds
// the last returned word while idle.
module dualmem_rdpipe
    import dualmem_pkg::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned RD_LAT = RD_LAT_ONE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] hold;

    if (RD_LAT == RD_LAT_TWO) begin : g_stage
        logic              stg_valid;
        logic [DATA_W-1:0] stg_data;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stg_valid <= 1'b0;
                stg_data  <= '0;
            end else begin
                stg_valid <= in_valid_i;
                if (in_valid_i) begin
                    stg_data <= in_data_i;
                end
            end
        end

        assign out_valid = stg_valid;
        assign out_data  = stg_data;
    end else begin : g_direct
        assign out_valid = in_valid_i;
        assign out_data  = in_data_i;
    end

    // The RAM output register cannot be reset, so the visible data comes from a
    // resettable hold register except in the cycle a new word is returned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold <= '0;
        end else if (out_valid) begin
            hold <= out_data;
        end
    end

    assign rvalid_o = out_valid;
    assign rdata_o  = out_valid ? out_data : hold;

endmodule

// File: rtl/dualmem_param.sv
// Two-port byte-enabled RAM, read-first, port A wins on colliding lanes,
// with an optional zeroing sweep after reset.
module dualmem_param
    import dualmem_pkg::*;
#(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned RD_LAT    = RD_LAT_ONE,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                init_busy_o,
    input  logic                a_req_i,
    input  logic                a_we_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic                a_gnt_o,
    output logic                a_rvalid_o,
    output logic [DATA_W-1:0]   a_rdata_o,
    input  logic                b_req_i,
    input  logic                b_we_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    output logic                b_gnt_o,
    output logic                b_rvalid_o,
    output logic [DATA_W-1:0]   b_rdata_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e            state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic              a_wr, a_rd, b_wr, b_rd;
    logic              a_rd_pend, b_rd_pend;
    logic [DATA_W-1:0] a_raw, b_raw;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= StReset;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        unique case (state)
            StReset: begin
                clr_cnt_next = '0;
                state_next   = INIT_ZERO ? StClear : StReady;
            end
            StClear: begin
                clr_cnt_next = clr_cnt + ADDR_W'(1);
                if (&clr_cnt) begin
                    state_next = StReady;
                end
            end
            StReady: ;
            default: state_next = StReset;
        endcase
    end

    assign init_busy_o = (state == StClear);
    assign a_gnt_o     = a_req_i && (state == StReady);
    assign b_gnt_o     = b_req_i && (state == StReady);
    assign a_wr        = a_gnt_o && a_we_i;
    assign a_rd        = a_gnt_o && !a_we_i;
    assign b_wr        = b_gnt_o && b_we_i;
    assign b_rd        = b_gnt_o && !b_we_i;

    // Port B lanes are assigned before port A so A's later NBA wins on overlap.
    always_ff @(posedge clk_i) begin
        if (state == StClear) begin
            mem[clr_cnt] <= '0;
        end
        for (int i = 0; i < BE_W; i++) begin
            if (b_wr && b_be_i[i]) begin
                mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
            end
            if (a_wr && a_be_i[i]) begin
                mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
        end
        if (a_rd) begin
            a_raw <= mem[a_addr_i];
        end
        if (b_rd) begin
            b_raw <= mem[b_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rd_pend <= 1'b0;
            b_rd_pend <= 1'b0;
        end else begin
            a_rd_pend <= a_rd;
            b_rd_pend <= b_rd;
        end
    end

    dualmem_rdpipe #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_rdpipe_a (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid_i(a_rd_pend),
        .in_data_i (a_raw),
        .rvalid_o  (a_rvalid_o),
        .rdata_o   (a_rdata_o)
    );

    dualmem_rdpipe #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_rdpipe_b (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid_i(b_rd_pend),
        .in_data_i (b_raw),
        .rvalid_o  (b_rvalid_o),
        .rdata_o   (b_rdata_o)
    );

endmodule
